// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag bit positions for the pipelined ALU.
// Opcodes 13/14 exist in the encoding even when saturation support is compiled out.
package alu_pkg;

  localparam int OP_W = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SHL   = 4'd5,
    OP_SHR   = 4'd6,
    OP_EQ    = 4'd7,
    OP_ADC   = 4'd8,
    OP_SBB   = 4'd9,
    OP_SRA   = 4'd10,
    OP_ROL   = 4'd11,
    OP_CMP   = 4'd12,
    OP_SADDU = 4'd13,
    OP_SSUBU = 4'd14,
    OP_ILL   = 4'd15
  } op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (op, a, b, carry-in) -> result, {V,N,Z,C}, illegal.
// Latency: none (pure logic). Backpressure: n/a, the enclosing pipeline stage owns handshakes.
// ALU_SAT_EN enables SADDU/SSUBU; without it opcodes 13/14 decode as illegal.
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;

  op_e                op_q;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum, adc, diff, sbb;
  logic [2*WIDTH-1:0] shl_w, shr_w, sra_w;
  logic [WIDTH-1:0]   fres;
  logic               c, v, use_diff;

  assign op_q = op_e'(op);
  assign sh   = b[SHW-1:0];

  assign sum  = {1'b0, a} + {1'b0, b};
  assign adc  = sum + {{WIDTH{1'b0}}, c_in};
  assign diff = {1'b0, a} - {1'b0, b};
  assign sbb  = diff - {{WIDTH{1'b0}}, c_in};

  // Shifting through a double-width window leaves the last bit shifted out
  // at a fixed position next to the result; it stays 0 for a zero shift.
  assign shl_w = {{WIDTH{1'b0}}, a} << sh;
  assign shr_w = {a, {WIDTH{1'b0}}} >> sh;
  assign sra_w = $signed({a, {WIDTH{1'b0}}}) >>> sh;

  always_comb begin
    res      = '0;
    c        = 1'b0;
    v        = 1'b0;
    illegal  = 1'b0;
    use_diff = 1'b0;
    case (op_q)
      OP_ADD: begin
        res = sum[MSB:0];
        c   = sum[WIDTH];
        v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_ADC: begin
        res = adc[MSB:0];
        c   = adc[WIDTH];
        v   = (a[MSB] == b[MSB]) && (adc[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res = diff[MSB:0];
        c   = diff[WIDTH];
        v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_SBB: begin
        res = sbb[MSB:0];
        c   = sbb[WIDTH];
        v   = (a[MSB] != b[MSB]) && (sbb[MSB] != a[MSB]);
      end
      OP_CMP: begin
        res      = a;
        use_diff = 1'b1;
        c        = diff[WIDTH];
        v        = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin
        res = shl_w[MSB:0];
        c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        res = shr_w[2*WIDTH-1:WIDTH];
        c   = shr_w[MSB];
      end
      OP_SRA: begin
        res = sra_w[2*WIDTH-1:WIDTH];
        c   = sra_w[MSB];
      end
      // Carry takes the bit that wrapped around.
      OP_ROL: begin
        res = {a[MSB-1:0], a[MSB]};
        c   = a[MSB];
      end
      OP_EQ: res = {{(WIDTH-1){1'b0}}, (a == b)};
`ifdef ALU_SAT_EN
      OP_SADDU: begin
        res = sum[WIDTH] ? '1 : sum[MSB:0];
        c   = sum[WIDTH];
      end
      OP_SSUBU: begin
        res = diff[WIDTH] ? '0 : diff[MSB:0];
        c   = diff[WIDTH];
      end
`endif
      default: illegal = 1'b1;
    endcase

    fres           = use_diff ? diff[MSB:0] : res;
    flags          = '0;
    flags[FLAG_C]  = c;
    flags[FLAG_Z]  = (fres == '0);
    flags[FLAG_N]  = fres[MSB];
    flags[FLAG_V]  = v;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with a persistent {V,N,Z,C} register for ADC/SBB chaining (ALU_SAT_EN adds SADDU/SSUBU).
// Latency: result registered 2 cycles after acceptance; 1 op/cycle sustained.
// Backpressure: output held while out_valid && !out_ready; in_ready drops only when both stages are full.
module alu_pipe import alu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [3:0]       out_flags,
  output logic             out_illegal,
  output logic             flag_c,
  input  logic             flag_clr
);

  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [3:0]       flag_q;
  logic             s2_load;
  logic [WIDTH-1:0] core_res;
  logic [3:0]       core_flags;
  logic             core_ill;

  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign flag_c   = flag_q[FLAG_C];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_a     <= in_a;
      s1_b     <= in_b;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Carry-in comes straight from the flag register, so an op that follows
  // directly behind another sees the flags that op just committed.
  alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
    .op      (s1_op),
    .a       (s1_a),
    .b       (s1_b),
    .c_in    (flag_q[FLAG_C]),
    .res     (core_res),
    .flags   (core_flags),
    .illegal (core_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_res     <= '0;
      out_flags   <= '0;
      out_illegal <= 1'b0;
    end else if (s2_load) begin
      out_valid   <= 1'b1;
      out_res     <= core_res;
      out_flags   <= core_ill ? flag_q : core_flags;
      out_illegal <= core_ill;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // A committing op takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= '0;
    end else if (s2_load && !core_ill) begin
      flag_q <= core_flags;
    end else if (flag_clr) begin
      flag_q <= '0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed spec cases plus randomized traffic against an integer reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, out_illegal, flag_c, flag_clr;
  logic [3:0] in_op, out_flags;
  logic [7:0] in_a, in_b, out_res;

  logic        v_in_valid, v_in_ready, v_out_valid, v_out_illegal, v_flag_c;
  logic [3:0]  v_in_op, v_out_flags;
  logic [15:0] v_in_a, v_in_b, v_out_res;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_flags(out_flags), .out_illegal(out_illegal),
    .flag_c(flag_c), .flag_clr(flag_clr)
  );

  alu_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v_in_valid), .in_ready(v_in_ready), .in_op(v_in_op),
    .in_a(v_in_a), .in_b(v_in_b), .out_valid(v_out_valid), .out_ready(1'b1),
    .out_res(v_out_res), .out_flags(v_out_flags), .out_illegal(v_out_illegal),
    .flag_c(v_flag_c), .flag_clr(1'b0)
  );

  typedef struct {
    logic [7:0] res;
    logic [3:0] fl;
    logic       ill;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] mflags;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_out   = 0;
  logic       rand_rdy_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy_en) out_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic ovf(input int sv);
    return (sv > 127) || (sv < -128);
  endfunction

  // Reference: opcode rules evaluated with plain integer arithmetic on 8-bit values.
  task automatic model_exec(input logic [3:0] op, input logic [7:0] a8, input logic [7:0] b8,
                            output exp_t e);
    int a, b, sa, sbv, sh, k, s, r, fr;
    logic cf, vf, ill;
    logic [7:0] f8;
    a   = int'(a8);
    b   = int'(b8);
    sa  = (a > 127) ? a - 256 : a;
    sbv = (b > 127) ? b - 256 : b;
    sh  = b % 8;
    k   = (op == OP_ADC || op == OP_SBB) ? int'(mflags[0]) : 0;
    cf = 1'b0; vf = 1'b0; ill = 1'b0; r = 0; s = 0; fr = -1;
    case (op)
      OP_ADD, OP_ADC: begin
        s = a + b + k; r = s & 255; cf = (s > 255); vf = ovf(sa + sbv + k);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        s = a - b - k; r = s & 255; cf = (s < 0); vf = ovf(sa - sbv - k);
        if (op == OP_CMP) begin fr = r; r = a; end
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: begin r = (a << sh) & 255; cf = (sh != 0) && (((a >> (8 - sh)) & 1) == 1); end
      OP_SHR: begin r = a >> sh; cf = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
      OP_SRA: begin r = (sa >>> sh) & 255; cf = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
      OP_ROL: begin r = ((a << 1) | (a >> 7)) & 255; cf = (a > 127); end
      OP_EQ:  r = (a == b) ? 1 : 0;
`ifdef ALU_SAT_EN
      OP_SADDU: begin s = a + b; cf = (s > 255); r = cf ? 255 : s; end
      OP_SSUBU: begin cf = (a < b); r = cf ? 0 : a - b; end
`endif
      default: ill = 1'b1;
    endcase
    if (fr < 0) fr = r;
    f8    = 8'(fr);
    e.res = 8'(r);
    e.ill = ill;
    if (ill) e.fl = mflags;
    else begin
      e.fl   = {vf, f8[7], (f8 == 8'h00), cf};
      mflags = e.fl;
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int   n;
    logic acc;
    exp_t e;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    n = 0; acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      n++;
      tick();
    end
    chk("send_accept", 32'(acc), 1);
    if (acc) begin
      model_exec(op, a, b, e);
      exp_q.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, 32'(out_valid), 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin tick(); n++; end
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  // Output monitor: in-order scoreboard plus stability while stalled.
  logic       hold_vld = 1'b0;
  logic [7:0] hold_res;
  logic [3:0] hold_fl;
  logic       hold_ill;
  exp_t       me;

  always @(negedge clk) begin
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        n_tests++;
        assert (out_valid === 1'b1 && out_res === hold_res && out_flags === hold_fl &&
                out_illegal === hold_ill) else begin
          n_fail++;
          $error("FAIL hold observed=%0b/%0h/%0h/%0b expected=1/%0h/%0h/%0b",
                 out_valid, out_res, out_flags, out_illegal, hold_res, hold_fl, hold_ill);
        end
      end
      if (out_valid && out_ready) begin
        n_out++;
        n_tests++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_result observed=%0h expected=none", out_res);
        end
        if (exp_q.size() > 0) begin
          me = exp_q.pop_front();
          n_tests++;
          assert (out_res === me.res && out_flags === me.fl && out_illegal === me.ill) else begin
            n_fail++;
            $error("FAIL result observed=%0h/%0h/%0b expected=%0h/%0h/%0b",
                   out_res, out_flags, out_illegal, me.res, me.fl, me.ill);
          end
        end
      end
      hold_vld = out_valid && !out_ready;
      hold_res = out_res;
      hold_fl  = out_flags;
      hold_ill = out_illegal;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    out_ready = 1'b1; flag_clr = 1'b0; mflags = '0;
    v_in_valid = 1'b0; v_in_op = '0; v_in_a = '0; v_in_b = '0;
    repeat (2) tick();
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_res", 32'(out_res), 0);
    chk("rst_out_flags", 32'(out_flags), 0);
    chk("rst_out_illegal", 32'(out_illegal), 0);
    chk("rst_flag_c", 32'(flag_c), 0);
    tick();

    // 16-bit chained add, issued back-to-back
    v_in_valid = 1'b1; v_in_op = OP_ADD; v_in_a = 16'hFFFF; v_in_b = 16'h0001;
    @(negedge clk); chk("w16_rdy0", 32'(v_in_ready), 1);
    tick();
    v_in_op = OP_ADC; v_in_a = 16'h0000; v_in_b = 16'h0000;
    @(negedge clk); chk("w16_rdy1", 32'(v_in_ready), 1);
    tick();
    v_in_valid = 1'b0;
    @(negedge clk);
    chk("w16_add_valid", 32'(v_out_valid), 1);
    chk("w16_add_res", 32'(v_out_res), 'h0000);
    @(negedge clk);
    chk("w16_adc_valid", 32'(v_out_valid), 1);
    chk("w16_adc_res", 32'(v_out_res), 'h0001);
    tick();

    // ADD 0xFF+0x01 with exact two-cycle latency
    send(OP_ADD, 8'hFF, 8'h01);
    @(negedge clk); chk("lat_early", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 1);
    chk("add_ff_res", 32'(out_res), 'h00);
    chk("add_ff_flags", 32'(out_flags), 'b0011);
    chk("add_ff_flag_c", 32'(flag_c), 1);
    tick();

    send(OP_SUB, 8'h10, 8'h20); wait_out("sub");
    chk("sub_res", 32'(out_res), 'hF0);
    chk("sub_flags", 32'(out_flags), 'b0101);
    tick();
    send(OP_ADC, 8'h00, 8'h00); wait_out("adc");
    chk("adc_res", 32'(out_res), 'h01);
    chk("adc_flags", 32'(out_flags), 'b0000);
    tick();

    send(OP_ADD, 8'h7F, 8'h01); wait_out("ovf");
    chk("ovf_res", 32'(out_res), 'h80);
    chk("ovf_flags", 32'(out_flags), 'b1100);
    tick();
    send(OP_ILL, 8'h12, 8'h34); wait_out("ill");
    chk("ill_flag", 32'(out_illegal), 1);
    chk("ill_res", 32'(out_res), 0);
    chk("ill_flags_kept", 32'(out_flags), 'b1100);
    chk("ill_flag_c", 32'(flag_c), 0);
    tick();

    // Backpressure: consumer stalls for 5 cycles while 3 ops are offered
    out_ready = 1'b0;
    base = n_out;
    send(OP_ADD, 8'h01, 8'h02);
    send(OP_SUB, 8'h05, 8'h03);
    in_valid = 1'b1; in_op = OP_XOR; in_a = 8'hAA; in_b = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_res", 32'(out_res), 'h03);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(OP_XOR, 8'hAA, 8'h55);
    drain();
    chk("bp_delivered", 32'(n_out - base), 3);

    // flag_clr alone, then colliding with a flag load
    send(OP_ADD, 8'hFF, 8'h01); wait_out("clr_pre");
    chk("clr_pre_c", 32'(flag_c), 1);
    tick();
    flag_clr = 1'b1; tick(); flag_clr = 1'b0; mflags = '0;
    @(negedge clk); chk("clr_c", 32'(flag_c), 0);
    tick();
    send(OP_ADD, 8'hFF, 8'h01);
    flag_clr = 1'b1; tick(); flag_clr = 1'b0;
    @(negedge clk);
    chk("clr_coll_valid", 32'(out_valid), 1);
    chk("clr_coll_c", 32'(flag_c), 1);
    tick();

    // Randomized traffic with random consumer stalls
    rand_rdy_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end
    rand_rdy_en = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with both stages occupied
    out_ready = 1'b0;
    send(OP_ADD, 8'hFF, 8'h01);
    send(OP_AND, 8'h0F, 8'hF0);
    @(negedge clk);
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_flag_c", 32'(flag_c), 1);
    tick();
    rst = 1'b1; exp_q.delete(); mflags = '0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_in_ready", 32'(in_ready), 1);
    chk("mrst_flag_c", 32'(flag_c), 0);
    chk("mrst_out_res", 32'(out_res), 0);
    out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk); chk("mrst_no_result", 32'(out_valid), 0);
    tick();

    send(OP_SADDU, 8'hF0, 8'h20); wait_out("saddu");
`ifdef ALU_SAT_EN
    chk("saddu_res", 32'(out_res), 'hFF);
    chk("saddu_flags", 32'(out_flags), 'b0101);
    chk("saddu_ill", 32'(out_illegal), 0);
`else
    chk("saddu_ill", 32'(out_illegal), 1);
    chk("saddu_res", 32'(out_res), 0);
`endif
    tick();
    send(OP_SSUBU, 8'h10, 8'h20); wait_out("ssubu");
`ifdef ALU_SAT_EN
    chk("ssubu_res", 32'(out_res), 'h00);
    chk("ssubu_flags", 32'(out_flags), 'b0011);
`else
    chk("ssubu_ill", 32'(out_illegal), 1);
    chk("ssubu_res", 32'(out_res), 0);
`endif
    tick();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
